// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with valid/ready word output and error flags
// Optional UART_RX_OS_MAJORITY_EN: each bit decided by a 2-of-3 vote around the bit centre.
module uart_rx_os #(
    parameter int DATA_W_MAX = 9,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic [3:0]            data_bits,
    input  logic                  parity_en,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic [DATA_W_MAX-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
`ifdef UART_RX_OS_MAJORITY_EN
    localparam logic [PH_W-1:0] PH_V0   = PH_W'(OVERSAMPLE / 2 - 2);
    localparam logic [PH_W-1:0] PH_V1   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_SAMP = PH_W'(OVERSAMPLE / 2);
`else
    localparam logic [PH_W-1:0] PH_SAMP = PH_W'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
    } state_t;

    state_t                  state;
    logic                    rx_s1, rx_s2, rx_prev;
    logic [1:0]              sync_fill;
    logic [DIV_W-1:0]        tick_cnt, div_q;
    logic [PH_W-1:0]         phase;
    logic [3:0]              bit_cnt, nbits_q;
    logic                    par_en_q, stop2_q;
    logic [1:0]              par_mode_q;
    logic [DATA_W_MAX-1:0]   shreg;
    logic                    any_one, perr, ferr;
    logic                    fall, tick, samp, bit_end, bit_val;
    logic                    done, brk_n, ferr_n, exp_par;

`ifdef UART_RX_OS_MAJORITY_EN
    logic v0, v1;
    assign bit_val = (v0 & v1) | (v0 & rx_s2) | (v1 & rx_s2);
`else
    assign bit_val = rx_s2;
`endif

    // rx_prev stays 0 until the synchroniser holds a real sample, so a line
    // that is already low after reset must go high before it can start a frame.
    assign fall    = rx_prev & ~rx_s2;
    assign tick    = (state != S_IDLE) && (tick_cnt == '0);
    assign samp    = tick && (phase == PH_SAMP);
    assign bit_end = tick && (phase == PH_LAST);
    assign exp_par = par_mode_q[0] ^ (par_mode_q[1] & (^shreg));
    assign done    = samp && ((state == S_STOP1 && !stop2_q) || state == S_STOP2);
    assign brk_n   = !any_one && !bit_val;
    assign ferr_n  = ferr | !bit_val;
    assign busy_o  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b0;
            sync_fill    <= '0;
            state        <= S_IDLE;
            tick_cnt     <= '0;
            div_q        <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
            nbits_q      <= 4'd8;
            par_en_q     <= 1'b0;
            par_mode_q   <= '0;
            stop2_q      <= 1'b0;
            shreg        <= '0;
            any_one      <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
`ifdef UART_RX_OS_MAJORITY_EN
            v0           <= 1'b1;
            v1           <= 1'b1;
`endif
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            rx_prev   <= (sync_fill == 2'd2) ? rx_s2 : 1'b0;
            overrun_o <= 1'b0;
            if (valid_o && ready_i)
                valid_o <= 1'b0;

            if (state == S_IDLE)
                tick_cnt <= baud_div;
            else if (tick)
                tick_cnt <= div_q;
            else
                tick_cnt <= tick_cnt - DIV_W'(1);

            if (tick)
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
`ifdef UART_RX_OS_MAJORITY_EN
            if (tick && phase == PH_V0)
                v0 <= rx_s2;
            if (tick && phase == PH_V1)
                v1 <= rx_s2;
`endif

            case (state)
                S_IDLE: if (fall) begin
                    state      <= S_START;
                    div_q      <= baud_div;
                    tick_cnt   <= baud_div;
                    phase      <= '0;
                    bit_cnt    <= '0;
                    nbits_q    <= data_bits;
                    par_en_q   <= parity_en;
                    par_mode_q <= parity_mode;
                    stop2_q    <= stop_bits;
                    shreg      <= '0;
                    any_one    <= 1'b0;
                    perr       <= 1'b0;
                    ferr       <= 1'b0;
                end
                S_START: begin
                    if (samp && bit_val)
                        state <= S_IDLE;
                    else if (bit_end)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (samp) begin
                        shreg <= shreg | (DATA_W_MAX'(bit_val) << bit_cnt);
                        if (bit_val)
                            any_one <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_cnt == nbits_q - 4'd1)
                            state <= par_en_q ? S_PARITY : S_STOP1;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (samp) begin
                        perr <= (bit_val != exp_par);
                        if (bit_val)
                            any_one <= 1'b1;
                    end
                    if (bit_end)
                        state <= S_STOP1;
                end
                S_STOP1: begin
                    if (samp) begin
                        ferr <= ferr_n;
                        if (bit_val)
                            any_one <= 1'b1;
                    end
                    if (bit_end)
                        state <= S_STOP2;
                end
                S_STOP2:     ;
                S_WAIT_HIGH: if (rx_s2) state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase

            // Finish at the last stop-bit centre so the next start edge is not missed.
            if (done) begin
                state <= brk_n ? S_WAIT_HIGH : S_IDLE;
                if (!valid_o || ready_i) begin
                    data_o       <= brk_n ? '0 : shreg;
                    parity_err_o <= perr & !brk_n;
                    frame_err_o  <= ferr_n;
                    break_o      <= brk_n;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - self-checking bench for uart_rx_os
module tb_uart_rx_os;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       br;
    } word_t;

    typedef struct {
        logic [8:0] data;
        int         nbits;
        bit         pen;
        logic [1:0] mode;
        bit         pbit;
        bit         stop2;
        bit         stop_val;
        logic [8:0] e_data;
        bit         e_pe;
        bit         e_fe;
        bit         e_br;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic [8:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        parity_err_o, frame_err_o, break_o, overrun_o, busy_o;

    always #5 clk = ~clk;

    uart_rx_os dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .data_bits(data_bits),
        .parity_en(parity_en), .parity_mode(parity_mode), .stop_bits(stop_bits),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .break_o(break_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    fall_cyc = 0;
    int    rise_cyc = 0;
    int    ovr_cnt  = 0;
    logic  valid_d  = 1'b0;
    word_t got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o && ready_i)
            got_q.push_back('{data_o, parity_err_o, frame_err_o, break_o});
        if (overrun_o)
            ovr_cnt++;
        if (valid_o && !valid_d)
            rise_cyc = cyc;
        valid_d = valid_o;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input word_t w, input word_t e);
        check({name, "_data"}, int'(w.d), int'(e.d));
        check({name, "_perr"}, int'(w.pe), int'(e.pe));
        check({name, "_ferr"}, int'(w.fe), int'(e.fe));
        check({name, "_brk"},  int'(w.br), int'(e.br));
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit pen,
                              input logic [1:0] md, input bit pb, input bit s2,
                              input bit sv, input int div);
        int t;
        t           = 16 * (div + 1);
        baud_div    = 16'(div);
        data_bits   = 4'(nb);
        parity_en   = pen;
        parity_mode = md;
        stop_bits   = s2;
        fall_cyc    = cyc;
        hold(1'b0, t);
        for (int i = 0; i < nb; i++)
            hold(d[i], t);
        if (pen)
            hold(pb, t);
        hold(sv, t);
        if (s2)
            hold(sv, t);
        hold(1'b1, 2 * t);
    endtask

    task automatic wait_word(output word_t w);
        int n = 0;
        while (got_q.size() == 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL word_timeout: got no word, expected one within 2000 clk");
            w = '{9'h0, 1'b0, 1'b0, 1'b0};
        end else begin
            w = got_q.pop_front();
        end
    endtask

    function automatic bit model_par(input logic [8:0] d, input logic [1:0] md);
        int ones = $countones(d);
        case (md)
            2'b10:   return (ones % 2) == 1;
            2'b11:   return (ones % 2) == 0;
            2'b01:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic word_t model_word(input logic [8:0] d, input int nb, input bit pen,
                                         input logic [1:0] md, input bit pb, input bit sv);
        word_t      w;
        logic [8:0] m;
        bit         brk;
        m    = d & 9'((1 << nb) - 1);
        brk  = (m == 9'h0) && (!pen || !pb) && !sv;
        w.d  = brk ? 9'h0 : m;
        w.br = brk;
        w.fe = !sv;
        w.pe = pen && !brk && (pb != model_par(m, md));
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[7];
        word_t      w, e;
        int         lat, ovr0, div, nb;
        bit         pen, s2, sv, pb;
        logic [1:0] md;
        logic [8:0] d;

        tbl[0] = '{9'h0A5, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{9'h055, 7, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{9'h03C, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{9'h012, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 9'h012, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{9'h1FF, 9, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{9'h00B, 5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 9'h00B, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{9'h000, 8, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; rx = 1'b1; ready_i = 1'b1; baud_div = 16'd3; data_bits = 4'd8;
        parity_en = 1'b0; parity_mode = 2'b00; stop_bits = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_flags", {parity_err_o, frame_err_o, break_o, overrun_o}, 0);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].nbits, tbl[i].pen, tbl[i].mode, tbl[i].pbit,
                       tbl[i].stop2, tbl[i].stop_val, 3);
            wait_word(w);
            e = '{tbl[i].e_data, tbl[i].e_pe, tbl[i].e_fe, tbl[i].e_br};
            check_word($sformatf("vec%0d", i), w, e);
            if (i == 0) begin
                lat = rise_cyc - fall_cyc;
                check("latency_611", (lat >= 610 && lat <= 612) ? 611 : lat, 611);
            end
        end

        for (int i = 0; i < 16; i++) begin
            div = $urandom_range(0, 3);
            nb  = $urandom_range(5, 9);
            pen = 1'($urandom_range(0, 1));
            md  = 2'($urandom_range(0, 3));
            s2  = 1'($urandom_range(0, 1));
            sv  = ($urandom_range(0, 4) != 0);
            d   = 9'($urandom);
            pb  = model_par(d & 9'((1 << nb) - 1), md) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, nb, pen, md, pb, s2, sv, div);
            wait_word(w);
            check_word($sformatf("rnd%0d", i), w, model_word(d, nb, pen, md, pb, sv));
        end

        baud_div = 16'd3; data_bits = 4'd8; parity_en = 1'b0; stop_bits = 1'b0;
        hold(1'b0, 16);
        check("false_start_busy_on", busy_o, 1);
        hold(1'b1, 24);
        check("false_start_busy_off", busy_o, 0);
        hold(1'b1, 100);
        check("false_start_no_word", got_q.size(), 0);

        ready_i = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(9'h011, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3);
        send_frame(9'h022, 8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        check("ovr_held_data", data_o, 9'h011);
        check("ovr_held_valid", valid_o, 1);
        ready_i = 1'b1;
        hold(1'b1, 2);
        check("ovr_one_transfer", got_q.size(), 1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check("ovr_transfer_data", w.d, 9'h011);
        end
        hold(1'b1, 640);
        check("ovr_no_second", got_q.size(), 0);
        check("ovr_valid_low", valid_o, 0);

        ready_i = 1'b0;
        ovr0 = ovr_cnt;
        hold(1'b0, 12 * 64);
        hold(1'b1, 2 * 64);
        check("brk_valid", valid_o, 1);
        check_word("brk", '{data_o, parity_err_o, frame_err_o, break_o},
                   '{9'h000, 1'b0, 1'b1, 1'b1});
        hold(1'b1, 12 * 64);
        check("brk_no_further", ovr_cnt - ovr0, 0);
        check("brk_idle", busy_o, 0);

        hold(1'b0, 3 * 64);
        check("rst_mid_busy", busy_o, 1);
        rst = 1'b1;
        hold(1'b0, 3);
        check("rst_mid_valid", valid_o, 0);
        check("rst_mid_busy_off", busy_o, 0);
        check("rst_mid_flags", {parity_err_o, frame_err_o, break_o, overrun_o}, 0);
        rst = 1'b0;
        ready_i = 1'b1;
        hold(1'b0, 5 * 64);
        hold(1'b1, 4 * 64);
        check("rst_mid_no_word", got_q.size(), 0);
        check("rst_mid_no_valid", valid_o, 0);
        check("rst_mid_idle", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver and successor to the simple clock-driven receiver. It generates its own oversampling tick from `clk` and supports runtime data length, parity, stop bits and baud divisor. Outputs are a valid/ready stream carrying per-word parity, framing, break and overrun status. It sits between the Pmod RX pin and any stream consumer, such as a FIFO or command parser.

## Interface
- `DATA_W_MAX`, default 9: widest supported data field; `data_o` width.
- `OVERSAMPLE`, default 16: ticks per bit; even, ≥4.
- `DIV_W`, default 16: width of `baud_div`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial input; asynchronous to `clk`; idles high.
- `baud_div` in DIV_W: tick period is `baud_div+1` clk cycles; latched at start detection.
- `data_bits` in 4: data length, 5..DATA_W_MAX; latched at start detection.
- `parity_en` in 1: enables the parity bit.
- `parity_mode` in 2: 11 odd, 10 even, 01 mark, 00 space.
- `stop_bits` in 1: 0 = 1 stop bit, 1 = 2 stop bits.
- `data_o` out DATA_W_MAX: received word, LSB-first on the line, right-justified, upper bits zero.
- `valid_o` out 1: word available.
- `ready_i` in 1: consumer accepts.
- `parity_err_o` out 1: qualifies the held word.
- `frame_err_o` out 1: qualifies the held word.
- `break_o` out 1: qualifies the held word.
- `overrun_o` out 1: one-cycle pulse.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- Input stage: `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Tick counter:
  - Counts down from the latched `baud_div` and emits a tick at 0.
  - In IDLE it is held at `baud_div`.
  - It is reloaded on the detected falling edge.
- Phase counter: counts 0..OVERSAMPLE-1 per bit. The sample point is tick OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE→START: synchronised `rx` falls.
  - START: mid-bit sample of 1 is a false start → IDLE with no output. Sample of 0 → DATA at the end of the bit.
  - DATA: shift `data_bits` samples. → PARITY if `parity_en`, else → STOP1.
  - PARITY: expected bit = `parity_mode[0]` XOR (`parity_mode[1]` AND XOR of the data bits). A mismatch sets the parity-error flag.
  - STOP1: mid-bit sample of 0 sets frame error. → STOP2 if `stop_bits`, else the frame completes at this sample.
  - STOP2: same check as STOP1; the frame completes at this sample.
- Completion happens at the mid-bit sample of the last stop bit, not at the bit end, so the next start edge can be caught within the remaining half bit.
  - If a break is detected → WAIT_HIGH.
  - Otherwise → IDLE.
- Break: all data bits, the parity bit (if enabled) and the stop bit(s) sampled 0. The word is delivered with `data_o`=0, `break_o`=1, `frame_err_o`=1.
- WAIT_HIGH: stays until synchronised `rx`=1, then → IDLE.
- Output register and handshake:
  - At completion the word and flags load if `valid_o`=0, or if `valid_o`&`ready_i` in the same cycle.
  - Otherwise the new frame is dropped, `overrun_o` pulses for one cycle, and the held word and flags are unchanged.
  - A transfer occurs on `valid_o`&`ready_i`. `valid_o` falls the next cycle unless a new word loads in that same cycle.
  - `data_o` and the flags are stable while `valid_o`=1.
- Reset:
  - All outputs go to 0 and the FSM to IDLE.
  - Asserting `rst` mid-frame discards the frame.
  - After release, a line already low is not treated as a start until it has been seen high.

## Timing
- Bit period T = OVERSAMPLE·(baud_div+1) clk.
- Start detection occurs 2 clk after the `rx` fall (synchroniser).
- `valid_o` rises 1 clk after the last stop mid-sample, at (1 + data_bits + parity_en + stop_bits + 0.5)·T + 3 clk ±1 after the line fall.
- `baud_div`=0 means a tick every clk.
- Divisor and format changes apply only at the next start detection.

## Configuration
- Macro: `UART_RX_OS_MAJORITY_EN`.
- Defined: each bit value is the 2-of-3 majority of samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The start validation uses the same majority.
- Undefined: a single sample at tick OVERSAMPLE/2; the vote registers are removed.

## Test plan
All cases use OVERSAMPLE=16 and baud_div=3, so T=64 clk.
1. 8N1 frame 0xA5, `ready_i`=1 → `valid_o` rises 611±1 clk after the fall; `data_o`=0x0A5; all flags 0.
2. 7E2 frame with data 0x55 and parity bit 1 (wrong) → `data_o`=0x055, `parity_err_o`=1, `frame_err_o`=0.
3. 8N1 frame 0x3C with stop bit 0 → `data_o`=0x03C, `frame_err_o`=1; FSM returns to IDLE and a following 0x12 frame is received clean.
4. `rx` low for 16 clk then high → no `valid_o`; `busy_o` back to 0 within 40 clk.
5. `ready_i`=0 and frames 0x11 then 0x22 → `overrun_o` pulses once; `data_o` stays 0x011. Raising `ready_i` transfers 0x011; no 0x022 follows.
6. `rx` low for 12·T, then high (8N1) → one word with `data_o`=0, `break_o`=1, `frame_err_o`=1, and no further word. Asserting `rst` mid-frame on the next frame clears all outputs and produces no word.
